// File: rtl/rsfq_split_pair_monitor.sv
// Pairs the toggle-encoded pulses from a splitter's two output branches.
// Measures branch skew and per-branch pulse spacing, and queues each pair or orphan as an event.
module rsfq_split_pair_monitor #(
  parameter int unsigned TS_W     = 16,
  parameter int unsigned SKEW_MAX = 4,
  parameter int unsigned MIN_GAP  = 3,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned SW      = $clog2(SKEW_MAX + 1),
  localparam int unsigned DW      = TS_W + SW + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a0,
  input  logic             a1,
  input  logic             clr_err,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [DW-1:0]    ev_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             err_skew,
  output logic [1:0]       err_gap,
  output logic             err_ovf
);

  // Elapsed must be able to hold SKEW_MAX + 1, the timeout value.
  localparam int unsigned EW = $clog2(SKEW_MAX + 2);
  localparam int unsigned GW = $clog2(MIN_GAP + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait1, StWait0} state_e;

  state_e            state_q, state_d;
  logic              a0_q, a1_q;
  logic              p0, p1;
  logic [1:0]        p;
  logic [TS_W-1:0]   ts_q, lead_ts_q, lead_ts_d;
  logic [EW-1:0]     elapsed_q, elapsed_d, elapsed_cur;
  logic              lead, p_wait, p_lead;
  logic              push, orphan;
  logic [DW-1:0]     push_data;

  assign p0          = a0 ^ a0_q;
  assign p1          = a1 ^ a1_q;
  assign p           = {p1, p0};
  assign elapsed_cur = elapsed_q + EW'(1);
  assign lead        = (state_q == StWait0);
  assign p_wait      = lead ? p0 : p1;
  assign p_lead      = lead ? p1 : p0;

  always_comb begin
    push      = 1'b0;
    orphan    = 1'b0;
    push_data = '0;
    state_d   = state_q;
    lead_ts_d = lead_ts_q;
    elapsed_d = elapsed_cur;
    unique case (state_q)
      StIdle: begin
        if (p0 && p1) begin
          push      = 1'b1;
          push_data = {ts_q, SW'(0), 1'b0, 1'b0};
        end else if (p0 || p1) begin
          state_d   = p0 ? StWait1 : StWait0;
          lead_ts_d = ts_q;
          elapsed_d = '0;
        end
      end
      StWait1, StWait0: begin
        if (elapsed_cur == EW'(SKEW_MAX + 1)) begin
          // Timeout: any pulse arriving now starts a fresh split.
          push      = 1'b1;
          orphan    = 1'b1;
          push_data = {lead_ts_q, SW'(SKEW_MAX), lead, 1'b1};
          lead_ts_d = ts_q;
          elapsed_d = '0;
          if (p0)      state_d = StWait1;
          else if (p1) state_d = StWait0;
          else         state_d = StIdle;
        end else if (p_wait) begin
          push      = 1'b1;
          push_data = {lead_ts_q, elapsed_cur[SW-1:0], lead, 1'b0};
          if (p_lead) begin
            lead_ts_d = ts_q;
            elapsed_d = '0;
          end else begin
            state_d   = StIdle;
          end
        end else if (p_lead) begin
          push      = 1'b1;
          orphan    = 1'b1;
          push_data = {lead_ts_q, elapsed_cur[SW-1:0], lead, 1'b1};
          lead_ts_d = ts_q;
          elapsed_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a0_q      <= 1'b0;
      a1_q      <= 1'b0;
      ts_q      <= '0;
      lead_ts_q <= '0;
      elapsed_q <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      state_q   <= state_d;
      a0_q      <= a0;
      a1_q      <= a1;
      ts_q      <= ts_q + TS_W'(1);
      lead_ts_q <= lead_ts_d;
      elapsed_q <= elapsed_d;
      cnt0      <= cnt0 + CNT_W'(p0);
      cnt1      <= cnt1 + CNT_W'(p1);
    end
  end

  // Per-branch spacing check; since_q saturates at MIN_GAP.
  logic [GW-1:0] since_q [2];
  logic [1:0]    seen_q;
  logic [1:0]    gap_viol;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      gap_viol[i] = p[i] && seen_q[i] && (since_q[i] < GW'(MIN_GAP));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        since_q[i] <= '0;
        seen_q[i]  <= 1'b0;
      end else if (p[i]) begin
        since_q[i] <= GW'(1);
        seen_q[i]  <= 1'b1;
      end else if (since_q[i] != GW'(MIN_GAP)) begin
        since_q[i] <= since_q[i] + GW'(1);
      end
    end
  end

  // Event FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          full, pop, push_ok, drop;

  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign ev_valid = (wptr_q != rptr_q);
  assign ev_data  = mem_q[rptr_q[AW-1:0]];
  assign pop      = ev_valid && ev_ready;
  assign push_ok  = push && (!full || pop);
  assign drop     = push && !push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= push_data;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Sticky flags: a new error in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_skew <= 1'b0;
      err_gap  <= '0;
      err_ovf  <= 1'b0;
    end else begin
      err_skew <= (err_skew & ~clr_err) | orphan;
      err_gap  <= (err_gap & ~{2{clr_err}}) | gap_viol;
      err_ovf  <= (err_ovf & ~clr_err) | drop;
    end
  end

endmodule

// File: tb/tb_rsfq_split_pair_monitor.sv
// Directed bench for rsfq_split_pair_monitor: pairing, skew bounds, orphans, gap errors, FIFO
// overflow and same-cycle push/pop, reset during a pending split.
module tb_rsfq_split_pair_monitor;

  logic        clk = 1'b0;
  logic        rst, a0, a1, clr_err, ev_ready;
  logic        ev_valid;
  logic [20:0] ev_data;
  logic [15:0] cnt0, cnt1;
  logic        err_skew, err_ovf;
  logic [1:0]  err_gap;

  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;  // ts value the next posedge samples

  always #5 clk = ~clk;

  rsfq_split_pair_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .a0       (a0),
    .a1       (a1),
    .clr_err  (clr_err),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .err_skew (err_skew),
    .err_gap  (err_gap),
    .err_ovf  (err_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] mk_ev(input int ts, input int skew, input bit ld, input bit orph);
    return {16'(ts), 3'(skew), ld, orph};
  endfunction

  task automatic step();
    @(posedge clk);
    tcyc++;
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic advance_to(input int t);
    while (tcyc < t) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; a0 = 1'b0; a1 = 1'b0; clr_err = 1'b0; ev_ready = 1'b0;
    step();
    step();
    rst  = 1'b0;
    tcyc = 0;
  endtask

  task automatic pop_expect(input string tag, input logic [20:0] exp);
    check_eq({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check_eq(tag, 32'(ev_data), 32'(exp));
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_data", 32'(ev_data), 32'd0);
    check_eq("rst_cnt0", 32'(cnt0), 32'd0);
    check_eq("rst_cnt1", 32'(cnt1), 32'd0);
    check_eq("rst_errs", 32'({err_skew, err_gap, err_ovf}), 32'd0);

    // 1: simultaneous pulses at ts=10
    advance_to(10);
    a0 = ~a0; a1 = ~a1;
    step();
    check_eq("t1_cnt0", 32'(cnt0), 32'd1);
    check_eq("t1_cnt1", 32'(cnt1), 32'd1);
    check_eq("t1_errs", 32'({err_skew, err_gap, err_ovf}), 32'd0);
    pop_expect("t1_ev", mk_ev(10, 0, 0, 0));
    check_eq("t1_empty", 32'(ev_valid), 32'd0);

    // 2: q0 leads by 3 cycles
    do_reset();
    advance_to(20);
    a0 = ~a0;
    step();
    advance_to(23);
    check_eq("t2_pending", 32'(ev_valid), 32'd0);
    a1 = ~a1;
    step();
    check_eq("t2_skew_err", 32'(err_skew), 32'd0);
    pop_expect("t2_ev", mk_ev(20, 3, 0, 0));

    // 2b: skew exactly SKEW_MAX still pairs
    do_reset();
    advance_to(20);
    a0 = ~a0;
    step();
    advance_to(24);
    a1 = ~a1;
    step();
    check_eq("t2b_skew_err", 32'(err_skew), 32'd0);
    pop_expect("t2b_ev", mk_ev(20, 4, 0, 0));

    // 3: q1 orphan times out at ts=45
    do_reset();
    advance_to(40);
    a1 = ~a1;
    step();
    advance_to(45);
    check_eq("t3_not_yet", 32'(ev_valid), 32'd0);
    step();
    check_eq("t3_skew_err", 32'(err_skew), 32'd1);
    pop_expect("t3_ev", mk_ev(40, 4, 1, 1));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check_eq("t3_cleared", 32'(err_skew), 32'd0);
    // q0 twice with no q1: second pulse emits an orphan while clr_err is high
    begin
      int t0;
      t0 = tcyc;
      a0 = ~a0;
      step();
      tick(2);
      a0 = ~a0; clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check_eq("t3_set_wins", 32'(err_skew), 32'd1);
      pop_expect("t3_orphan0", mk_ev(t0, 3, 0, 1));
    end

    // 4: q0 spacing of 2 cycles
    do_reset();
    advance_to(50);
    a0 = ~a0;
    step();
    a1 = ~a1;
    step();
    a0 = ~a0;
    step();
    advance_to(54);
    a1 = ~a1;
    step();
    check_eq("t4_gap", 32'(err_gap), 32'b01);
    check_eq("t4_cnt0", 32'(cnt0), 32'd2);
    check_eq("t4_cnt1", 32'(cnt1), 32'd2);
    pop_expect("t4_ev0", mk_ev(50, 1, 0, 0));
    pop_expect("t4_ev1", mk_ev(52, 2, 0, 0));

    // 5: overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      a0 = ~a0; a1 = ~a1;
      step();
      tick(2);
    end
    check_eq("t5_ovf", 32'(err_ovf), 32'd1);
    check_eq("t5_gap", 32'(err_gap), 32'd0);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("t5_ev%0d", i), mk_ev(3 * i, 0, 0, 0));
    check_eq("t5_empty", 32'(ev_valid), 32'd0);

    // 6: push into a full FIFO while popping
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a0 = ~a0; a1 = ~a1;
      step();
      tick(2);
    end
    check_eq("t6_full_ovf", 32'(err_ovf), 32'd0);
    ev_ready = 1'b1; a0 = ~a0; a1 = ~a1;
    step();
    ev_ready = 1'b0;
    check_eq("t6_no_drop", 32'(err_ovf), 32'd0);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("t6_ev%0d", i), mk_ev(3 * i, 0, 0, 0));
    check_eq("t6_empty", 32'(ev_valid), 32'd0);

    // 6b: reset while a split is pending and the FIFO is non-empty
    tick(3);
    a0 = ~a0; a1 = ~a1;
    step();
    tick(3);
    a0 = ~a0;
    step();
    check_eq("t6b_pre_valid", 32'(ev_valid), 32'd1);
    rst = 1'b1; a0 = 1'b0; a1 = 1'b0;
    step();
    check_eq("t6b_rst_valid", 32'(ev_valid), 32'd0);
    rst  = 1'b0;
    tcyc = 0;
    tick(8);
    check_eq("t6b_no_orphan", 32'(ev_valid), 32'd0);
    check_eq("t6b_skew_err", 32'(err_skew), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
